button_debouncer: RTL
=====================

# button_debouncer

- Conditions WIDTH independent, already-synchronized button/switch inputs into clean levels plus one-cycle press pulses.
- Sits directly downstream of the 2-flop synchronizer in the io_circuits path.
- Feeds the FPGA top level and the CPU's memory-mapped button/switch registers.
- A shared free-running sample timer paces per-bit saturating counters; a bit is "pressed" only after staying high across PULSE_CNT_MAX consecutive sample ticks.

## Interface
- WIDTH, 1: number of independent input bits.
- SAMPLE_CNT_MAX, 62500: clk cycles per sample tick; must be ≥ 2.
- PULSE_CNT_MAX, 200: consecutive high samples required to assert; must be ≥ 1.
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- glitchy_signal  in  WIDTH  synchronized but bouncing inputs.
- debounced_signal  out  WIDTH  clean level per bit; reset value 0.
- press_pulse  out  WIDTH  one-cycle high on each 0→1 of debounced_signal; reset value 0.

## Operation
- Sample timer `sample_cnt`:
  - Width `$clog2(SAMPLE_CNT_MAX)`.
  - Counts 0 … SAMPLE_CNT_MAX-1, then wraps to 0.
  - `tick` = (sample_cnt == SAMPLE_CNT_MAX-1), combinational.
  - Shared by all bits; never stalls.
- Per-bit counter `sat_cnt[i]`, width `$clog2(PULSE_CNT_MAX+1)`. Priority order:
  - glitchy_signal[i]==0: cleared to 0 next cycle, regardless of tick.
  - Else, if tick and sat_cnt[i] < PULSE_CNT_MAX: increment.
  - Else: hold; saturates at PULSE_CNT_MAX, never wraps.
- Outputs:
  - debounced_signal[i] = (sat_cnt[i] == PULSE_CNT_MAX). Decoded from registers only, so glitch-free.
  - deb_q: one-cycle-delayed register of debounced_signal.
  - press_pulse[i] = debounced_signal[i] & ~deb_q[i].
- No release pulse. Release is immediate: any single low cycle drops the level.
- Bits are fully independent except for the shared tick.
- rst (any cycle, including mid-count): sample_cnt, all sat_cnt and deb_q cleared next edge. Outputs are 0 in the cycle after rst is sampled high.

## Timing
- Cycle 0 = first cycle with rst low; sample_cnt = 0.
- Ticks occur on cycles SAMPLE_CNT_MAX-1, 2·SAMPLE_CNT_MAX-1, ….
- Input held high from cycle 0: debounced_signal rises at cycle PULSE_CNT_MAX·SAMPLE_CNT_MAX. press_pulse is high in that same cycle only.
- Input high arriving mid-period: assertion latency lies between (PULSE_CNT_MAX-1)·SAMPLE_CNT_MAX+1 and PULSE_CNT_MAX·SAMPLE_CNT_MAX cycles.
- Input low on cycle n:
  - debounced_signal low at cycle n+1.
  - Re-qualification restarts from zero at the next tick.
- Input low in the same cycle as a tick: the clear wins; no increment.
- press_pulse always lasts exactly one cycle, and never occurs twice without an intervening deassert of debounced_signal.

## Structure
- No shared package entry needed. Counter widths are localparams derived from the parameters.
- Factor the output stage into one sub-module, `edge_detector` (WIDTH param; clk, signal_in, edge_detect_pulse). It is reused elsewhere for synchronized inputs.
- Sample timer and saturating counters live in button_debouncer, using a generate loop over WIDTH.

## Test plan
Bench parameters: WIDTH=2, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3.
- Steady high:
  - Stimulus: bit0 = 1 from cycle 0.
  - Required: ticks at 3, 7, 11; debounced_signal[0] = 1 from cycle 12 on; press_pulse[0] = 1 only at cycle 12; bit1 outputs stay 0.
- Bounce:
  - Stimulus: bit0 = 1 from cycle 0, low for cycle 9 only.
  - Required: sat_cnt cleared at cycle 10; debounced rises at cycle 20, not 12; exactly one pulse, at cycle 20.
- Release:
  - Stimulus: after qualification, bit0 low at cycle 30.
  - Required: debounced_signal[0] = 0 at cycle 31; press_pulse stays 0.
  - Stimulus: bit0 re-raised at cycle 32.
  - Required: re-asserts at cycle 44 with a single pulse.
- Low on tick:
  - Stimulus: bit0 high except low exactly on cycle 7.
  - Required: no increment on that tick; assertion delayed to cycle 20.
- Independence and reset:
  - Stimulus: bit1 = 1 from cycle 2, bit0 = 1 from cycle 0.
  - Required: both assert at cycle 12, with simultaneous pulses.
  - Stimulus: rst high on cycle 14.
  - Required: all outputs 0 at cycle 15; re-qualification completes at 15+12 = cycle 27.

Source files
------------

// File: rtl/button_debouncer_pkg.sv
// Shared helpers for the button debouncer: counter width derivation.
package button_debouncer_pkg;

   // Width of a counter that must hold values 0 .. max_val-1, never narrower than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val > 1) ? $clog2(max_val) : 1;
   endfunction

endpackage

// File: rtl/edge_detector.sv
// Rising-edge detector: one-cycle pulse on every 0->1 transition of each input bit.
module edge_detector #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] signal_in,
   output logic [WIDTH-1:0] edge_detect_pulse
);

   logic [WIDTH-1:0] r_deb_q;

   always_ff @(posedge clk) begin
      if (rst) r_deb_q <= '0;
      else     r_deb_q <= signal_in;
   end

   assign edge_detect_pulse = signal_in & ~r_deb_q;

endmodule

// File: rtl/button_debouncer.sv
// Debounces WIDTH synchronized inputs: a bit asserts only after PULSE_CNT_MAX
// consecutive high samples of a shared sample timer; any low cycle releases it.
module button_debouncer
   import button_debouncer_pkg::*;
#(
   parameter int WIDTH          = 1,
   parameter int SAMPLE_CNT_MAX = 62500,
   parameter int PULSE_CNT_MAX  = 200
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] glitchy_signal,
   output logic [WIDTH-1:0] debounced_signal,
   output logic [WIDTH-1:0] press_pulse
);

   localparam int SAMPLE_W = cnt_width(SAMPLE_CNT_MAX);
   localparam int SAT_W    = cnt_width(PULSE_CNT_MAX + 1);
   localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = SAMPLE_W'(SAMPLE_CNT_MAX - 1);
   localparam logic [SAT_W-1:0]    SAT_MAX     = SAT_W'(PULSE_CNT_MAX);

   logic [SAMPLE_W-1:0] r_sample_cnt;
   logic                w_tick;
   logic [WIDTH-1:0]    w_debounced;

   assign w_tick = (r_sample_cnt == SAMPLE_LAST);

   // Free-running timer shared by every bit; it never stalls on input activity.
   always_ff @(posedge clk) begin
      if (rst)         r_sample_cnt <= '0;
      else if (w_tick) r_sample_cnt <= '0;
      else             r_sample_cnt <= r_sample_cnt + SAMPLE_W'(1);
   end

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [SAT_W-1:0] r_sat_cnt;

      // A low input clears ahead of any tick, so a low cycle on a tick never counts.
      always_ff @(posedge clk) begin
         if (rst)                                  r_sat_cnt <= '0;
         else if (!glitchy_signal[gi])             r_sat_cnt <= '0;
         else if (w_tick && (r_sat_cnt < SAT_MAX)) r_sat_cnt <= r_sat_cnt + SAT_W'(1);
      end

      assign w_debounced[gi] = (r_sat_cnt == SAT_MAX);
   end

   assign debounced_signal = w_debounced;

   edge_detector #(
      .WIDTH (WIDTH)
   ) u_edge_detector (
      .clk               (clk),
      .rst               (rst),
      .signal_in         (w_debounced),
      .edge_detect_pulse (press_pulse)
   );

endmodule
